// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - opcodes, FSM states, ALU ops, trap codes and decoder of the multi-cycle core
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_ILLEGAL  = 2'd1,
    TRAP_MISALIGN = 2'd2
  } trap_t;

  typedef struct packed {
    logic    legal;
    logic    is_r;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    is_jump;
    logic    is_link;
    logic    zext;
    logic    wr_rd;
    logic    wr_rt;
    alu_op_t alu_op;
  } dec_t;

  // Illegal encodings decode to an all-zero record so a non-trapping core treats them as NOP.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct,
                                  input logic [4:0] shamt);
    dec_t d;
    d = '0;
    d.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        d.is_r  = 1'b1;
        d.wr_rd = 1'b1;
        d.legal = (shamt == 5'd0);
        case (funct)
          FN_ADDU: d.alu_op = ALU_ADD;
          FN_SUBU: d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_SLT:  d.alu_op = ALU_SLT;
          default: d.legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin d.legal = 1'b1; d.wr_rt = 1'b1; end
      OP_ORI:  begin d.legal = 1'b1; d.wr_rt = 1'b1; d.zext = 1'b1; d.alu_op = ALU_OR; end
      OP_LUI:  begin d.legal = 1'b1; d.wr_rt = 1'b1; d.alu_op = ALU_LUI; end
      OP_LW:   begin d.legal = 1'b1; d.wr_rt = 1'b1; d.is_load = 1'b1; end
      OP_SW:   begin d.legal = 1'b1; d.is_store = 1'b1; end
      OP_BEQ:  begin d.legal = 1'b1; d.is_branch = 1'b1; d.alu_op = ALU_SUB; end
      OP_J:    begin d.legal = 1'b1; d.is_jump = 1'b1; end
      OP_JAL:  begin d.legal = 1'b1; d.is_jump = 1'b1; d.is_link = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) begin
      d = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/mc_cpu_core_if.sv
// rtl/mc_cpu_core_if.sv - shared instruction/data memory port with req/ack handshake
interface mc_cpu_core_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output we, output addr, output wdata,
                  input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata,
                  output rdata, output ack);
endinterface

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - combinational ALU, modulo-2^32 arithmetic and signed set-less-than
module mc_alu
  import mc_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      ALU_LUI: result = {b[15:0], 16'h0000};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 32x32 register file, two async read ports, one write port, $0 hardwired to zero
module mc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mc_cpu_core.sv
// rtl/mc_cpu_core.sv - multi-cycle MIPS-subset core over a shared req/ack memory port
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32,
  parameter bit          TRAP_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  mc_cpu_core_if.master    mem,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       trap_cause
);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic             retire_q;
  logic [CNT_W-1:0] instret_q;
  trap_t            trap_q;

  logic [31:0] pc_d, pc_plus4, br_target, jmp_target, imm_ext;
  logic [31:0] rf_a, rf_b, rf_wdata, alu_b, alu_res, mem_addr_c;
  logic [4:0]  rf_waddr;
  logic        pc_ld, ir_ld, op_ld, alu_ld, mdr_ld, trap_ld, rf_we, retire_d;
  logic        req_fsm, mem_we_c, alu_zero;
  trap_t       trap_d;
  dec_t        dec;

  wire [4:0] rs = ir_q[25:21];
  wire [4:0] rt = ir_q[20:16];
  wire [4:0] rd = ir_q[15:11];

  assign dec        = decode(ir_q[31:26], ir_q[5:0], ir_q[10:6]);
  assign pc_plus4   = pc_q + 32'd4;
  assign br_target  = pc_plus4 + {imm_q[29:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign imm_ext    = dec.zext ? {16'h0000, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
  assign alu_b      = (dec.is_r || dec.is_branch) ? b_q : imm_q;

  mc_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  mc_alu u_alu (
    .a      (a_q),
    .b      (alu_b),
    .op     (dec.alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_ld      = 1'b0;
    ir_ld      = 1'b0;
    op_ld      = 1'b0;
    alu_ld     = 1'b0;
    mdr_ld     = 1'b0;
    trap_ld    = 1'b0;
    trap_d     = TRAP_NONE;
    rf_we      = 1'b0;
    rf_waddr   = rd;
    rf_wdata   = alu_q;
    retire_d   = 1'b0;
    req_fsm    = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = pc_q;
    case (state_q)
      S_FETCH: begin
        req_fsm = 1'b1;
        if (mem.ack) begin
          ir_ld   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_ld = 1'b1;
        if (!dec.legal && TRAP_EN) begin
          trap_ld = 1'b1;
          trap_d  = TRAP_ILLEGAL;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec.is_load || dec.is_store) begin
          alu_ld = 1'b1;
          if (alu_res[1:0] != 2'b00) begin
            if (TRAP_EN) begin
              trap_ld = 1'b1;
              trap_d  = TRAP_MISALIGN;
              state_d = S_HALT;
            end else begin
              pc_ld    = 1'b1;
              pc_d     = pc_plus4;
              retire_d = 1'b1;
              state_d  = S_FETCH;
            end
          end else begin
            state_d = S_MEM;
          end
        end else if (dec.is_branch) begin
          pc_ld    = 1'b1;
          pc_d     = alu_zero ? br_target : pc_plus4;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (dec.is_jump) begin
          // The link value is pc+4 of the jal itself; pc_q still holds that address here.
          pc_ld    = 1'b1;
          pc_d     = jmp_target;
          rf_we    = dec.is_link;
          rf_waddr = 5'd31;
          rf_wdata = pc_plus4;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else begin
          alu_ld  = 1'b1;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        req_fsm    = 1'b1;
        mem_we_c   = dec.is_store;
        mem_addr_c = alu_q;
        if (mem.ack) begin
          if (dec.is_store) begin
            pc_ld    = 1'b1;
            pc_d     = pc_plus4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_ld  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = dec.wr_rd | dec.wr_rt;
        rf_waddr = dec.wr_rd ? rd : rt;
        rf_wdata = dec.is_load ? mdr_q : alu_q;
        pc_ld    = 1'b1;
        pc_d     = pc_plus4;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retire_q  <= 1'b0;
      instret_q <= '0;
      trap_q    <= TRAP_NONE;
    end else begin
      if (pc_ld)   pc_q   <= pc_d;
      if (ir_ld)   ir_q   <= mem.rdata;
      if (alu_ld)  alu_q  <= alu_res;
      if (mdr_ld)  mdr_q  <= mem.rdata;
      if (trap_ld) trap_q <= trap_d;
      if (op_ld) begin
        a_q   <= rf_a;
        b_q   <= rf_b;
        imm_q <= imm_ext;
      end
      retire_q <= retire_d;
      if (retire_d) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  // Reset gates the request combinationally so an abandoned transaction is dropped at once.
  assign mem.req   = req_fsm & ~rst;
  assign mem.we    = mem_we_c;
  assign mem.addr  = mem_addr_c;
  assign mem.wdata = b_q;

  assign pc         = pc_q;
  assign instr      = ir_q;
  assign retire     = retire_q;
  assign instret    = instret_q;
  assign halted     = (state_q == S_HALT);
  assign trap_cause = trap_q;

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb/tb_mc_cpu_core.sv - directed-program bench for mc_cpu_core with a wait-state memory model
module tb_mc_cpu_core;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk, rst;
  logic [31:0] pc, instr;
  logic        retire, halted;
  logic [31:0] instret;
  logic [1:0]  trap_cause;

  mc_cpu_core_if mem ();

  mc_cpu_core #(.RESET_PC(RPC), .CNT_W(32), .TRAP_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem),
    .pc         (pc),
    .instr      (instr),
    .retire     (retire),
    .instret    (instret),
    .halted     (halted),
    .trap_cause (trap_cause)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_arr [4096];
  int          wait_n = 0;
  int          wcnt;
  int          stab_err = 0;
  int          cyc = 0;
  int          ret_q[$];
  logic [31:0] txn_addr_q[$];
  logic        txn_we_q[$];
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: responds at the falling edge after wait_n wait cycles.
  initial begin
    mem.ack = 1'b0;
    mem.rdata = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem.ack) wcnt = 0;
      mem.ack = 1'b0;
      if (mem.req && !rst) begin
        if (wcnt == 0) begin
          txn_addr_q.push_back(mem.addr);
          txn_we_q.push_back(mem.we);
          hold_addr = mem.addr; hold_we = mem.we; hold_wdata = mem.wdata;
        end else if (mem.addr !== hold_addr || mem.we !== hold_we || mem.wdata !== hold_wdata) begin
          stab_err++;
        end
        if (wcnt >= wait_n) begin
          mem.ack = 1'b1;
          if (mem.we) mem_arr[mem.addr[13:2]] = mem.wdata;
          else        mem.rdata = mem_arr[mem.addr[13:2]];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (retire === 1'b1) ret_q.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic hold_reset(input int w);
    rst = 1'b1;
    wait_n = w;
    step();
    step();
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'd0;
  endtask

  task automatic release_reset();
    ret_q.delete();
    txn_addr_q.delete();
    txn_we_q.delete();
    stab_err = 0;
    rst = 1'b0;
  endtask

  task automatic prog(input int idx, input logic [31:0] word);
    mem_arr[12'hC00 + idx] = word;
  endtask

  task automatic run_to_halt(input int max_cycles);
    for (int i = 0; i < max_cycles && halted !== 1'b1; i++) step();
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, max_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    vectors += 7;
    if (mem.req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", mem.req); end
    if (pc !== RPC) begin miscompares++; $display("FAIL rst_pc: got %h want %h", pc, RPC); end
    if (instr !== 32'd0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", instr); end
    if (retire !== 1'b0) begin miscompares++; $display("FAIL rst_retire: got %b want 0", retire); end
    if (instret !== 32'd0) begin miscompares++; $display("FAIL rst_instret: got %0d want 0", instret); end
    if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted); end
    if (trap_cause !== 2'd0) begin miscompares++; $display("FAIL rst_trap: got %0d want 0", trap_cause); end
  endtask

  task automatic test_zero_wait();
    hold_reset(0);
    prog(0, i_ins(6'b001101, 5'd0, 5'd1, 16'd5));
    prog(1, i_ins(6'b001000, 5'd1, 5'd2, 16'hFFFD));
    prog(2, r_ins(5'd1, 5'd2, 5'd3, 6'b100001));
    release_reset();
    run_to_halt(100);
    vectors += 8;
    if (dut.u_rf.regs[1] !== 32'd5) begin miscompares++; $display("FAIL zw_r1: got %h want 5", dut.u_rf.regs[1]); end
    if (dut.u_rf.regs[2] !== 32'd2) begin miscompares++; $display("FAIL zw_r2: got %h want 2", dut.u_rf.regs[2]); end
    if (dut.u_rf.regs[3] !== 32'd7) begin miscompares++; $display("FAIL zw_r3: got %h want 7", dut.u_rf.regs[3]); end
    if (instret !== 32'd3) begin miscompares++; $display("FAIL zw_instret: got %0d want 3", instret); end
    if (pc !== RPC + 32'd12) begin miscompares++; $display("FAIL zw_pc: got %h want %h", pc, RPC + 32'd12); end
    if (trap_cause !== 2'd1) begin miscompares++; $display("FAIL zw_trap: got %0d want 1", trap_cause); end
    if (ret_q.size() != 3) begin
      miscompares++; $display("FAIL zw_retires: got %0d want 3", ret_q.size());
    end else begin
      if (ret_q[1] - ret_q[0] != 4) begin miscompares++; $display("FAIL zw_gap1: got %0d want 4", ret_q[1] - ret_q[0]); end
      if (ret_q[2] - ret_q[1] != 4) begin miscompares++; $display("FAIL zw_gap2: got %0d want 4", ret_q[2] - ret_q[1]); end
    end
  endtask

  task automatic test_alu_ops();
    hold_reset(0);
    prog(0, i_ins(6'b001111, 5'd0, 5'd1, 16'h8000));
    prog(1, i_ins(6'b001101, 5'd0, 5'd2, 16'h00F0));
    prog(2, r_ins(5'd1, 5'd2, 5'd3, 6'b101010));
    prog(3, r_ins(5'd2, 5'd1, 5'd4, 6'b101010));
    prog(4, r_ins(5'd2, 5'd1, 5'd5, 6'b100011));
    prog(5, r_ins(5'd1, 5'd5, 5'd6, 6'b100100));
    prog(6, r_ins(5'd2, 5'd1, 5'd7, 6'b100101));
    prog(7, i_ins(6'b001000, 5'd2, 5'd0, 16'd5));
    prog(8, i_ins(6'b000100, 5'd1, 5'd2, 16'd4));
    prog(9, r_ins(5'd0, 5'd2, 5'd8, 6'b100001));
    release_reset();
    run_to_halt(200);
    vectors += 10;
    if (dut.u_rf.regs[1] !== 32'h8000_0000) begin miscompares++; $display("FAIL alu_lui: got %h want 80000000", dut.u_rf.regs[1]); end
    if (dut.u_rf.regs[3] !== 32'd1) begin miscompares++; $display("FAIL alu_slt_neg: got %h want 1", dut.u_rf.regs[3]); end
    if (dut.u_rf.regs[4] !== 32'd0) begin miscompares++; $display("FAIL alu_slt_pos: got %h want 0", dut.u_rf.regs[4]); end
    if (dut.u_rf.regs[5] !== 32'h8000_00F0) begin miscompares++; $display("FAIL alu_subu: got %h want 800000f0", dut.u_rf.regs[5]); end
    if (dut.u_rf.regs[6] !== 32'h8000_0000) begin miscompares++; $display("FAIL alu_and: got %h want 80000000", dut.u_rf.regs[6]); end
    if (dut.u_rf.regs[7] !== 32'h8000_00F0) begin miscompares++; $display("FAIL alu_or: got %h want 800000f0", dut.u_rf.regs[7]); end
    if (dut.u_rf.regs[0] !== 32'd0) begin miscompares++; $display("FAIL alu_r0: got %h want 0", dut.u_rf.regs[0]); end
    if (dut.u_rf.regs[8] !== 32'h0000_00F0) begin miscompares++; $display("FAIL alu_beq_nt: got %h want f0", dut.u_rf.regs[8]); end
    if (pc !== 32'h0000_3028) begin miscompares++; $display("FAIL alu_pc: got %h want 3028", pc); end
    if (instret !== 32'd10) begin miscompares++; $display("FAIL alu_instret: got %0d want 10", instret); end
  endtask

  task automatic test_branch_jump();
    hold_reset(0);
    prog(0, i_ins(6'b000100, 5'd1, 5'd1, 16'd2));
    prog(1, i_ins(6'b001101, 5'd0, 5'd5, 16'h0055));
    prog(2, i_ins(6'b001101, 5'd0, 5'd5, 16'h0066));
    prog(3, {6'b000011, 26'h0000C10});
    release_reset();
    run_to_halt(100);
    vectors += 5;
    if (dut.u_rf.regs[31] !== 32'h0000_3010) begin miscompares++; $display("FAIL bj_link: got %h want 3010", dut.u_rf.regs[31]); end
    if (dut.u_rf.regs[5] !== 32'd0) begin miscompares++; $display("FAIL bj_skipped: got %h want 0", dut.u_rf.regs[5]); end
    if (pc !== 32'h0000_3040) begin miscompares++; $display("FAIL bj_pc: got %h want 3040", pc); end
    if (instret !== 32'd2) begin miscompares++; $display("FAIL bj_instret: got %0d want 2", instret); end
    if (txn_addr_q.size() != 3) begin
      miscompares++; $display("FAIL bj_fetches: got %0d want 3", txn_addr_q.size());
    end else begin
      vectors += 2;
      if (txn_addr_q[1] !== 32'h0000_300C) begin miscompares++; $display("FAIL bj_fetch1: got %h want 300c", txn_addr_q[1]); end
      if (txn_addr_q[2] !== 32'h0000_3040) begin miscompares++; $display("FAIL bj_fetch2: got %h want 3040", txn_addr_q[2]); end
    end
    vectors++;
    if (ret_q.size() != 2 || ret_q[1] - ret_q[0] != 3) begin
      miscompares++; $display("FAIL bj_latency: retires=%0d gap=%0d want 2 and 3", ret_q.size(), (ret_q.size() == 2) ? ret_q[1] - ret_q[0] : -1);
    end
  endtask

  task automatic test_wait_states();
    hold_reset(3);
    mem_arr[0] = 32'hDEAD_BEEF;
    prog(0, i_ins(6'b001101, 5'd0, 5'd3, 16'd7));
    prog(1, i_ins(6'b101011, 5'd0, 5'd3, 16'd0));
    prog(2, i_ins(6'b100011, 5'd0, 5'd4, 16'd0));
    release_reset();
    run_to_halt(300);
    vectors += 5;
    if (dut.u_rf.regs[4] !== 32'd7) begin miscompares++; $display("FAIL ws_lw: got %h want 7", dut.u_rf.regs[4]); end
    if (mem_arr[0] !== 32'd7) begin miscompares++; $display("FAIL ws_sw: got %h want 7", mem_arr[0]); end
    if (stab_err != 0) begin miscompares++; $display("FAIL ws_stable: got %0d changes want 0", stab_err); end
    if (instret !== 32'd3) begin miscompares++; $display("FAIL ws_instret: got %0d want 3", instret); end
    if (ret_q.size() != 3) begin
      miscompares++; $display("FAIL ws_retires: got %0d want 3", ret_q.size());
    end else begin
      vectors += 2;
      if (ret_q[1] - ret_q[0] != 10) begin miscompares++; $display("FAIL ws_sw_lat: got %0d want 10", ret_q[1] - ret_q[0]); end
      if (ret_q[2] - ret_q[1] != 11) begin miscompares++; $display("FAIL ws_lw_lat: got %0d want 11", ret_q[2] - ret_q[1]); end
    end
  endtask

  task automatic test_illegal();
    int req_seen;
    hold_reset(0);
    prog(0, i_ins(6'b001101, 5'd0, 5'd1, 16'd9));
    prog(1, 32'hFC00_0000);
    release_reset();
    run_to_halt(100);
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem.req !== 1'b0) req_seen++;
      step();
    end
    vectors += 6;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL ill_halted: got %b want 1", halted); end
    if (trap_cause !== 2'd1) begin miscompares++; $display("FAIL ill_cause: got %0d want 1", trap_cause); end
    if (instret !== 32'd1) begin miscompares++; $display("FAIL ill_instret: got %0d want 1", instret); end
    if (pc !== 32'h0000_3004) begin miscompares++; $display("FAIL ill_pc: got %h want 3004", pc); end
    if (instr !== 32'hFC00_0000) begin miscompares++; $display("FAIL ill_ir: got %h want fc000000", instr); end
    if (req_seen != 0) begin miscompares++; $display("FAIL ill_req: got %0d req cycles want 0", req_seen); end
  endtask

  task automatic test_misaligned();
    int low_req;
    hold_reset(0);
    prog(0, i_ins(6'b001101, 5'd0, 5'd1, 16'd2));
    prog(1, i_ins(6'b100011, 5'd1, 5'd2, 16'd0));
    release_reset();
    run_to_halt(100);
    low_req = 0;
    foreach (txn_addr_q[i]) if (txn_addr_q[i] < RPC) low_req++;
    vectors += 5;
    if (trap_cause !== 2'd2) begin miscompares++; $display("FAIL mis_cause: got %0d want 2", trap_cause); end
    if (instret !== 32'd1) begin miscompares++; $display("FAIL mis_instret: got %0d want 1", instret); end
    if (pc !== 32'h0000_3004) begin miscompares++; $display("FAIL mis_pc: got %h want 3004", pc); end
    if (txn_addr_q.size() != 2) begin miscompares++; $display("FAIL mis_txns: got %0d want 2", txn_addr_q.size()); end
    if (low_req != 0) begin miscompares++; $display("FAIL mis_datareq: got %0d data requests want 0", low_req); end
  endtask

  task automatic test_reset_mid_fetch();
    hold_reset(2);
    prog(0, i_ins(6'b001101, 5'd0, 5'd1, 16'd5));
    prog(1, i_ins(6'b001000, 5'd1, 5'd2, 16'hFFFD));
    prog(2, r_ins(5'd1, 5'd2, 5'd3, 6'b100001));
    release_reset();
    for (int i = 0; i < 100 && instret !== 32'd1; i++) step();
    vectors++;
    if (!(mem.req === 1'b1 && mem.ack === 1'b0 && instret === 32'd1)) begin
      miscompares++; $display("FAIL rmf_setup: req=%b ack=%b instret=%0d want 1 0 1", mem.req, mem.ack, instret);
    end
    rst = 1'b1;
    step();
    vectors += 4;
    if (mem.req !== 1'b0) begin miscompares++; $display("FAIL rmf_req: got %b want 0", mem.req); end
    if (pc !== RPC) begin miscompares++; $display("FAIL rmf_pc: got %h want %h", pc, RPC); end
    if (instret !== 32'd0) begin miscompares++; $display("FAIL rmf_instret: got %0d want 0", instret); end
    if (retire !== 1'b0) begin miscompares++; $display("FAIL rmf_retire: got %b want 0", retire); end
    step();
    vectors++;
    if (mem.req !== 1'b0) begin miscompares++; $display("FAIL rmf_req_hold: got %b want 0", mem.req); end
    rst = 1'b0;
    #1;
    vectors++;
    if (mem.req !== 1'b1 || mem.addr !== RPC) begin
      miscompares++; $display("FAIL rmf_resume: req=%b addr=%h want 1 %h", mem.req, mem.addr, RPC);
    end
    run_to_halt(200);
    vectors += 2;
    if (dut.u_rf.regs[3] !== 32'd7) begin miscompares++; $display("FAIL rmf_r3: got %h want 7", dut.u_rf.regs[3]); end
    if (instret !== 32'd3) begin miscompares++; $display("FAIL rmf_instret_end: got %0d want 3", instret); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_zero_wait();
    test_alu_ops();
    test_branch_jump();
    test_wait_states();
    test_illegal();
    test_misaligned();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
